// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types and helpers for the memory slave.
//   htrans_e / hsize_e / hburst_e : bus encodings
//   HRESP_OKAY / HRESP_ERROR      : response codes
//   state_e                       : slave data-phase FSM states
//   lane_mask()                   : little-endian byte-lane enable decode
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  // Byte lanes touched by a transfer of 2^size bytes at byte offset addr_lo
  // within a data_w-bit word. Lane i carries byte address (word base + i).
  function automatic logic [7:0] lane_mask(input logic [2:0] size,
                                           input logic [2:0] addr_lo,
                                           input int         data_w);
    int nb, off, n;
    logic [7:0] m;
    nb  = data_w / 8;
    n   = 1 << size;
    off = int'(addr_lo) % nb;
    m   = '0;
    for (int i = 0; i < 8; i++)
      if (i < nb && i >= off && i < off + n) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// DEPTH x DATA_W storage, one byte-wide array per lane.
//   gclk/grst_n : clock, async active-low reset (clears every word)
//   we/wbe      : write strobe and per-byte lane enables
//   waddr/wdata : write word index and data
//   raddr/rdata : combinational read port
module ahb_slave_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int NB    = DATA_W / 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              we,
  input  logic [NB-1:0]     wbe,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
        for (int i = 0; i < DEPTH; i++) lane_mem[i] <= '0;
      end else if (we && wbe[b]) begin
        lane_mem[waddr] <= wdata[8*b +: 8];
      end
    end

    assign rdata[8*b +: 8] = lane_mem[raddr];
  end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave with configurable wait states and ERROR responses.
//   HCLK/HRESETn            : clock, async active-low reset
//   HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HREADY : address phase
//   HWDATA                  : write data (data phase)
//   HRDATA/HREADYOUT/HRESP  : data-phase response
module ahb_lite_mem_slave
  import ahb_lite_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int NB     = DATA_W / 8;
  localparam int BSEL_W = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;

  // Registered address phase; pend_q marks an OKAY transfer whose data phase is live.
  logic              pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [2:0]        size_q;

  logic              sample, valid, err;
  logic              range_err, size_err, align_err;
  logic [ADDR_W-1:0] align_mask;
  logic              completing;
  logic [7:0]        mask_full;
  logic [DATA_W-1:0] mem_rdata;

  // Only accept a new address phase while our own data phase is not stalling.
  assign sample = HSEL & HREADY & HREADYOUT;
  assign valid  = HTRANS[1];

  assign align_mask = (ADDR_W'(1) << HSIZE) - ADDR_W'(1);
  assign range_err  = (HADDR >> BSEL_W) >= ADDR_W'(DEPTH);
  assign size_err   = HSIZE > 3'(BSEL_W);
  assign align_err  = |(HADDR & align_mask);
  assign err        = range_err | size_err | align_err;

  // The completing cycle of an OKAY transfer is always spent in IDLE.
  assign completing = (state_q == ST_IDLE) & pend_q;
  assign mask_full  = lane_mask(size_q, 3'(addr_q[BSEL_W-1:0]), DATA_W);

  ahb_slave_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .gclk   (HCLK),
    .grst_n (HRESETn),
    .we     (completing & write_q),
    .wbe    (mask_full[NB-1:0]),
    .waddr  (addr_q[BSEL_W +: IDX_W]),
    .wdata  (HWDATA),
    .raddr  (addr_q[BSEL_W +: IDX_W]),
    .rdata  (mem_rdata)
  );

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (HREADY) begin
          state_d = ST_IDLE;
          if (sample && valid) begin
            if (err) begin
              state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = 4'(WAIT_STATES - 1);
            end
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    unique case (state_q)
      ST_WAIT: HREADYOUT = 1'b0;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: if (completing && !write_q) HRDATA = mem_rdata;
    endcase
  end

  // Address-phase capture. Erroring transfers never set pend_q, so they
  // can never reach the write port.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q  <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else if (HREADY && HREADYOUT) begin
      pend_q <= HSEL & valid & ~err;
      if (HSEL) begin
        addr_q  <= HADDR;
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{HBURST, HTRANS[0], addr_q, mask_full};

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Two slaves (WAIT_STATES 0 and 2) behind a small tb-side interconnect,
// driven by a pipelined master and checked against a byte-addressed model.
module tb_ahb_lite_mem_slave;
  import ahb_lite_pkg::*;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel0, hsel1, hwrite, cur_slv, dsel;
  logic [31:0] haddr, hwdata, rdata0, rdata1, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic        rdy0, rdy1, resp0, resp1, hready, hresp;

  always #5 clk = ~clk;

  // Data-phase owner: follows the address phase accepted on each ready edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dsel <= 1'b0;
    else if (hready) dsel <= cur_slv;
  end

  assign hready = dsel ? rdy1   : rdy0;
  assign hresp  = dsel ? resp1  : resp0;
  assign hrdata = dsel ? rdata1 : rdata0;

  ahb_lite_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(0)) u_slv0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0));

  ahb_lite_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_STATES(2)) u_slv1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(rdata1), .HREADYOUT(rdy1), .HRESP(resp1));

  typedef struct {
    bit          slv;
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp_rdata;
    bit          exp_resp;
    int          exp_stall;
  } beat_t;

  beat_t      q[$];
  beat_t      tbl[$];
  logic [7:0] mb [2][1024];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(bit slv, logic [1:0] tr, bit wr, logic [2:0] sz,
                               logic [31:0] a, logic [31:0] d);
    beat_t b;
    b.slv = slv; b.sel = 1'b1; b.trans = tr; b.write = wr; b.size = sz;
    b.addr = a; b.wdata = d; b.chk = 1'b0; b.exp_rdata = '0; b.exp_resp = 1'b0;
    b.exp_stall = 0;
    return b;
  endfunction

  function automatic beat_t mkx(beat_t b, logic [31:0] er, bit ers, int est);
    beat_t r = b;
    r.chk = 1'b1; r.exp_rdata = er; r.exp_resp = ers; r.exp_stall = est;
    return r;
  endfunction

  // Reference model: byte-addressed memory, rules computed from address arithmetic.
  function automatic bit m_valid(beat_t b);
    return b.sel && b.trans[1];
  endfunction

  function automatic bit m_err(beat_t b);
    return (b.addr >= 32'(DEPTH * 4)) || (b.size > 3'd2) ||
           ((b.addr % (32'd1 << b.size)) != 0);
  endfunction

  function automatic logic [31:0] m_read(bit slv, logic [31:0] a);
    int base = int'(a) & ~3;
    return {mb[slv][base+3], mb[slv][base+2], mb[slv][base+1], mb[slv][base]};
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 1024; i++) mb[s][i] = 8'h00;
  endtask

  task automatic drive(input bit av, input beat_t a, input bit dv, input beat_t d);
    hsel0   = av && a.sel && !a.slv;
    hsel1   = av && a.sel && a.slv;
    cur_slv = av && a.slv;
    htrans  = av ? a.trans : HTRANS_IDLE;
    haddr   = av ? a.addr : 32'h0;
    hwrite  = av && a.write;
    hsize   = av ? a.size : 3'd0;
    hburst  = HBURST_INCR4;
    hwdata  = dv ? d.wdata : 32'h0;
  endtask

  task automatic complete(input beat_t d, input int stalls);
    bit v = m_valid(d);
    bit e = v && m_err(d);
    int est = !v ? 0 : e ? 1 : (d.slv ? 2 : 0);
    logic [31:0] erd = (v && !e && !d.write) ? m_read(d.slv, d.addr) : 32'h0;
    string tag = $sformatf("s%0d_%s@%0h", d.slv, d.write ? "wr" : "rd", d.addr);
    check({tag, "_stalls"}, 32'(stalls), 32'(est));
    check({tag, "_hresp"}, 32'(hresp), 32'(e));
    check({tag, "_hrdata"}, hrdata, erd);
    if (d.chk) begin
      check({tag, "_tbl_hrdata"}, hrdata, d.exp_rdata);
      check({tag, "_tbl_hresp"}, 32'(hresp), 32'(d.exp_resp));
      check({tag, "_tbl_stalls"}, 32'(stalls), 32'(d.exp_stall));
    end
    if (v && !e && d.write) begin
      for (int i = 0; i < (1 << d.size); i++)
        mb[d.slv][int'(d.addr) + i] = d.wdata[8*((int'(d.addr) % 4) + i) +: 8];
    end
  endtask

  // Pipelined master: pops beats from q, overlaps address and data phases.
  task automatic run(input int max_cyc);
    beat_t ap, dp;
    bit ap_v = 1'b0, dp_v = 1'b0;
    int stalls = 0, cyc = 0;
    if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
    drive(ap_v, ap, dp_v, dp);
    while ((ap_v || dp_v) && cyc < max_cyc) begin
      @(negedge clk);
      if (dp_v) begin
        if (!hready) begin
          stalls++;
          check("stall_hresp", 32'(hresp), 32'(m_valid(dp) && m_err(dp)));
          check("stall_hrdata", hrdata, 32'h0);
        end else begin
          complete(dp, stalls);
          dp_v = 1'b0;
          stalls = 0;
        end
      end
      if (hready) begin
        dp = ap; dp_v = ap_v;
        if (q.size() > 0) begin ap = q.pop_front(); ap_v = 1'b1; end
        else ap_v = 1'b0;
      end
      @(posedge clk); #1;
      drive(ap_v, ap, dp_v, dp);
      cyc++;
    end
    checks++;
    if (ap_v || dp_v) begin
      errors++;
      $display("FAIL run_timeout: got %0d cycles expected completion within %0d", cyc, max_cyc);
    end
  endtask

  initial begin
    beat_t b, idle;
    idle = mk(0, HTRANS_IDLE, 0, 0, 0, 0);
    drive(0, idle, 0, idle);
    m_clear();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy0", 32'(rdy0), 32'h1);
    check("rst_resp0", 32'(resp0), 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdy1", 32'(rdy1), 32'h1);
    check("rst_resp1", 32'(resp1), 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: {beat, expected hrdata, hresp, stall cycles}
    tbl.push_back(mkx(mk(0, HTRANS_NONSEQ, 1, 2, 32'h10, 32'hDEADBEEF), 0, 0, 0));
    tbl.push_back(mkx(mk(0, HTRANS_NONSEQ, 0, 2, 32'h10, 0), 32'hDEADBEEF, 0, 0));
    tbl.push_back(mkx(mk(0, HTRANS_NONSEQ, 1, 2, 32'h10, 32'h11223344), 0, 0, 0));
    tbl.push_back(mkx(mk(0, HTRANS_NONSEQ, 1, 0, 32'h13, 32'hAAAAAAAA), 0, 0, 0));
    tbl.push_back(mkx(mk(0, HTRANS_NONSEQ, 0, 2, 32'h10, 0), 32'hAA223344, 0, 0));
    tbl.push_back(mkx(mk(1, HTRANS_NONSEQ, 0, 2, 32'h0, 0), 32'h0, 0, 2));
    tbl.push_back(mkx(mk(0, HTRANS_NONSEQ, 1, 2, 32'h400, 32'h12345678), 0, 1, 1));
    tbl.push_back(mkx(mk(0, HTRANS_NONSEQ, 0, 2, 32'h0, 0), 32'h0, 0, 0));
    tbl.push_back(mkx(mk(0, HTRANS_NONSEQ, 1, 1, 32'h1, 32'hFFFFFFFF), 0, 1, 1));
    tbl.push_back(mkx(mk(0, HTRANS_NONSEQ, 0, 2, 32'h0, 0), 32'h0, 0, 0));
    tbl.push_back(mkx(mk(0, HTRANS_NONSEQ, 1, 3, 32'h8, 32'h55555555), 0, 1, 1));
    tbl.push_back(mkx(mk(0, HTRANS_NONSEQ, 1, 2, 32'h20, 32'h1), 0, 0, 0));
    tbl.push_back(mkx(mk(0, HTRANS_SEQ, 1, 2, 32'h24, 32'h2), 0, 0, 0));
    tbl.push_back(mkx(mk(0, HTRANS_BUSY, 1, 2, 32'h28, 32'hBADBAD), 0, 0, 0));
    tbl.push_back(mkx(mk(0, HTRANS_SEQ, 1, 2, 32'h28, 32'h3), 0, 0, 0));
    tbl.push_back(mkx(mk(0, HTRANS_SEQ, 1, 2, 32'h2C, 32'h4), 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mkx(mk(0, HTRANS_NONSEQ, 0, 2, 32'h20 + 32'(4 * i), 0), 32'(i + 1), 0, 0));
    tbl.push_back(mkx(mk(1, HTRANS_NONSEQ, 1, 1, 32'h2, 32'hBEEF0000), 0, 0, 2));
    tbl.push_back(mkx(mk(1, HTRANS_NONSEQ, 0, 2, 32'h0, 0), 32'hBEEF0000, 0, 2));
    for (int i = 0; i < tbl.size(); i++) q.push_back(tbl[i]);
    run(400);

    // Reset asserted during the wait state of a write to 0x30 on the wait-state slave.
    b = mk(1, HTRANS_NONSEQ, 1, 2, 32'h30, 32'hCAFEF00D);
    @(posedge clk); #1;
    drive(1, b, 0, idle);
    @(posedge clk); #1;
    drive(0, idle, 1, b);
    check("rstmid_wait_rdy1", 32'(rdy1), 32'h0);
    rst_n = 1'b0;
    #1;
    check("rstmid_rdy1", 32'(rdy1), 32'h1);
    check("rstmid_resp1", 32'(resp1), 32'h0);
    check("rstmid_rdata1", rdata1, 32'h0);
    drive(0, idle, 0, idle);
    m_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    q.push_back(mkx(mk(1, HTRANS_NONSEQ, 0, 2, 32'h30, 0), 32'h0, 0, 2));
    q.push_back(mkx(mk(0, HTRANS_NONSEQ, 0, 2, 32'h10, 0), 32'h0, 0, 0));
    run(100);

    // Randomized traffic across both slaves.
    for (int n = 0; n < 500; n++) begin
      int r;
      b.slv = 1'($urandom_range(0, 1));
      b.sel = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 9);
      b.trans = (r < 1) ? HTRANS_IDLE : (r < 2) ? HTRANS_BUSY : (r < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
      b.write = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 19);
      b.size = (r < 6) ? 3'd0 : (r < 12) ? 3'd1 : (r < 19) ? 3'd2 : 3'd3;
      r = $urandom_range(0, 19);
      if (r == 0) b.addr = 32'h400 + 32'($urandom_range(0, 255));
      else begin
        b.addr = 32'($urandom_range(0, 63)) & ~((32'd1 << b.size) - 32'd1);
        if (r == 1) b.addr = b.addr | 32'h1;
      end
      b.wdata = $urandom();
      b.chk = 1'b0; b.exp_rdata = '0; b.exp_resp = 1'b0; b.exp_stall = 0;
      q.push_back(b);
    end
    // Read back every word so earlier writes are observed.
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 64; a += 4) q.push_back(mk(1'(s), HTRANS_NONSEQ, 0, 2, 32'(a), 0));
    run(5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
